// File: rtl/atm_pkg.sv
`default_nettype none
// ============================================================================
// Module : atm_pkg
// Brief  : Key codes, keypad FSM state type and BCD word sizing for the ATM.
// Rev    : 1.0
// ============================================================================
package atm_pkg;

    localparam int DIGITS = 3;
    localparam int BCD_W  = 4 * DIGITS;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hE;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACCT = 3'd1,
        ST_PIN  = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4,
        ST_LOCK = 3'd5
    } kp_state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/atm_keypad_entry_if.sv
`default_nettype none
// ============================================================================
// Module : atm_keypad_entry_if
// Brief  : Keypad strobes, core verdicts and the words handed to the ATM core.
// Rev    : 1.0
// ============================================================================
interface atm_keypad_entry_if;
    import atm_pkg::*;

    logic             key_valid;
    logic [3:0]       key_code;
    logic             pass_ok;
    logic             pass_fail;
    logic             session_end;
    logic [BCD_W-1:0] Account_Number;
    logic [BCD_W-1:0] PIN;
    logic             acct_ready;
    logic             LC;
    logic             locked;
    logic             key_err;
    logic [1:0]       digit_count;
    logic [2:0]       tries;

    modport master (
        output key_valid, key_code, pass_ok, pass_fail, session_end,
        input  Account_Number, PIN, acct_ready, LC, locked, key_err,
               digit_count, tries
    );

    modport slave (
        input  key_valid, key_code, pass_ok, pass_fail, session_end,
        output Account_Number, PIN, acct_ready, LC, locked, key_err,
               digit_count, tries
    );

endinterface
`default_nettype wire

// File: rtl/bcd_digit_buffer.sv
`default_nettype none
// ============================================================================
// Module : bcd_digit_buffer
// Brief  : Three-deep BCD nibble shift register with count; clear > push > pop.
// Rev    : 1.0
// ============================================================================
module bcd_digit_buffer
    import atm_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [3:0]       i_digit,
    input  wire logic             i_pop,
    input  wire logic             i_clear,
    output logic      [BCD_W-1:0] o_data,
    output logic      [1:0]       o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    logic [BCD_W-1:0] r_data;
    logic [1:0]       r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= '0;
            r_count <= 2'd0;
        end else if (i_clear) begin
            r_data  <= '0;
            r_count <= 2'd0;
        end else if (i_push && !o_full) begin
            r_data  <= {r_data[BCD_W-5:0], i_digit};
            r_count <= r_count + 2'd1;
        end else if (i_pop && !o_empty) begin
            r_data  <= {4'd0, r_data[BCD_W-1:4]};
            r_count <= r_count - 2'd1;
        end
    end

    assign o_data  = r_data;
    assign o_count = r_count;
    assign o_full  = (r_count == 2'(DIGITS));
    assign o_empty = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/atm_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module : atm_keypad_entry
// Brief  : Keypad front end: account/PIN entry, retry lockout, idle timeout.
// Rev    : 1.0
// ============================================================================
module atm_keypad_entry
    import atm_pkg::*;
#(
    parameter int MAX_TRIES      = 3,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int LOCK_CYCLES    = 5000
)(
    input  wire logic        clk,
    input  wire logic        rst,
    atm_keypad_entry_if.slave kp
);

    localparam int c_TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int c_LCK_W = (LOCK_CYCLES > 1)    ? $clog2(LOCK_CYCLES)    : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_LCK_W-1:0] c_LCK_LAST = c_LCK_W'(LOCK_CYCLES - 1);
    localparam logic [2:0]         c_TRY_MAX  = 3'(MAX_TRIES);

    kp_state_t        r_state;
    logic [c_TMR_W-1:0] r_timer;
    logic [c_LCK_W-1:0] r_lock_cnt;
    logic [BCD_W-1:0] r_acct;
    logic [BCD_W-1:0] r_pin;
    logic             r_acct_ready;
    logic             r_lc;
    logic             r_locked;
    logic             r_key_err;
    logic [2:0]       r_tries;

    logic             w_in_entry;
    logic             w_sess_end;
    logic             w_ok;
    logic             w_fail;
    logic             w_timeout;
    logic             w_go_idle;
    logic             w_key;
    logic             w_is_digit;
    logic             w_push;
    logic             w_pop;
    logic             w_clear;
    logic             w_err;
    logic             w_enter;
    logic [2:0]       w_tries_nxt;
    logic [BCD_W-1:0] w_buf_data;
    logic [1:0]       w_count;
    logic             w_full;
    logic             w_empty;

    bcd_digit_buffer u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_digit (kp.key_code),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .o_data  (w_buf_data),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Event priority: session_end > pass_ok > pass_fail > timeout > key.
    always_comb begin
        w_in_entry  = (r_state == ST_ACCT) || (r_state == ST_PIN);
        w_sess_end  = kp.session_end && (r_state != ST_LOCK);
        w_ok        = kp.pass_ok && (r_state == ST_WAIT);
        w_fail      = kp.pass_fail && !kp.pass_ok && (r_state == ST_WAIT);
        w_timeout   = w_in_entry && (r_timer == c_TMR_LAST);
        w_go_idle   = w_sess_end || w_timeout ||
                      ((r_state == ST_LOCK) && (r_lock_cnt == c_LCK_LAST));
        w_key       = kp.key_valid && !w_sess_end && !w_ok && !w_fail && !w_timeout;
        w_is_digit  = is_digit(kp.key_code);
        w_tries_nxt = (r_tries == c_TRY_MAX) ? r_tries : r_tries + 3'd1;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_err       = 1'b0;
        w_enter     = 1'b0;
        w_clear     = w_go_idle || w_fail;
        if (w_key) begin
            if (r_state == ST_IDLE) begin
                w_push = w_is_digit;
            end else if (w_in_entry) begin
                if (w_is_digit) begin
                    w_push = !w_full;
                    w_err  = w_full;
                end else begin
                    case (kp.key_code)
                        KEY_CLEAR: w_clear = 1'b1;
                        KEY_BACK: begin
                            w_pop = !w_empty;
                            w_err = w_empty;
                        end
                        KEY_ENTER: begin
                            w_enter = w_full;
                            w_err   = !w_full;
                        end
                        default:   w_err = 1'b1;
                    endcase
                end
            end
        end
        // The shared buffer is emptied for PIN entry once the account is latched.
        if (w_enter && (r_state == ST_ACCT)) begin
            w_clear = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_lock_cnt   <= '0;
            r_acct       <= '0;
            r_pin        <= '0;
            r_acct_ready <= 1'b0;
            r_lc         <= 1'b0;
            r_locked     <= 1'b0;
            r_key_err    <= 1'b0;
            r_tries      <= 3'd0;
        end else begin
            r_key_err <= w_err;

            if (!w_in_entry || kp.key_valid || w_go_idle) begin
                r_timer <= '0;
            end else if (r_timer != c_TMR_LAST) begin
                r_timer <= r_timer + c_TMR_W'(1);
            end

            if ((r_state == ST_LOCK) && !w_go_idle) begin
                r_lock_cnt <= r_lock_cnt + c_LCK_W'(1);
            end else begin
                r_lock_cnt <= '0;
            end

            if (w_go_idle) begin
                r_state      <= ST_IDLE;
                r_acct       <= '0;
                r_pin        <= '0;
                r_acct_ready <= 1'b0;
                r_lc         <= 1'b0;
                r_locked     <= 1'b0;
                r_tries      <= 3'd0;
            end else if (w_ok) begin
                r_state <= ST_DONE;
            end else if (w_fail) begin
                r_lc    <= 1'b0;
                r_pin   <= '0;
                r_tries <= w_tries_nxt;
                if (w_tries_nxt == c_TRY_MAX) begin
                    r_state  <= ST_LOCK;
                    r_locked <= 1'b1;
                end else begin
                    r_state <= ST_PIN;
                end
            end else if (w_key) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_is_digit) begin
                            r_state <= ST_ACCT;
                        end
                    end
                    ST_ACCT: begin
                        if (w_enter) begin
                            r_acct       <= w_buf_data;
                            r_acct_ready <= 1'b1;
                            r_state      <= ST_PIN;
                        end
                    end
                    ST_PIN: begin
                        if (w_enter) begin
                            r_pin   <= w_buf_data;
                            r_lc    <= 1'b1;
                            r_state <= ST_WAIT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign kp.Account_Number = r_acct;
    assign kp.PIN            = r_pin;
    assign kp.acct_ready     = r_acct_ready;
    assign kp.LC             = r_lc;
    assign kp.locked         = r_locked;
    assign kp.key_err        = r_key_err;
    assign kp.digit_count    = w_count;
    assign kp.tries          = r_tries;

endmodule
`default_nettype wire

// File: tb/tb_atm_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module : tb_atm_keypad_entry
// Brief  : Directed self-checking bench for atm_keypad_entry.
// Rev    : 1.0
// ============================================================================
module tb_atm_keypad_entry;

    localparam int c_MAX  = 3;
    localparam int c_TMO  = 20;
    localparam int c_LOCK = 30;
    localparam logic [3:0] c_CLR = 4'hA;
    localparam logic [3:0] c_BCK = 4'hB;
    localparam logic [3:0] c_ENT = 4'hE;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;

    atm_keypad_entry_if kp();

    atm_keypad_entry #(
        .MAX_TRIES      (c_MAX),
        .TIMEOUT_CYCLES (c_TMO),
        .LOCK_CYCLES    (c_LOCK)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the key is sampled on the next rising edge.
    task automatic key(input logic [3:0] k);
        kp.key_valid = 1'b1;
        kp.key_code  = k;
        @(negedge clk);
        kp.key_valid = 1'b0;
        kp.key_code  = 4'd0;
    endtask

    task automatic strobe(input logic ok, input logic fail, input logic se);
        kp.pass_ok     = ok;
        kp.pass_fail   = fail;
        kp.session_end = se;
        @(negedge clk);
        kp.pass_ok     = 1'b0;
        kp.pass_fail   = 1'b0;
        kp.session_end = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic enter3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        key(a); key(b); key(c); key(c_ENT);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_acct"},  32'(kp.Account_Number), 32'h0);
        chk({tag, "_pin"},   32'(kp.PIN),            32'h0);
        chk({tag, "_ready"}, 32'(kp.acct_ready),     32'h0);
        chk({tag, "_lc"},    32'(kp.LC),             32'h0);
        chk({tag, "_tries"}, 32'(kp.tries),          32'h0);
        chk({tag, "_cnt"},   32'(kp.digit_count),    32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int err_sum;
        int lc;
        n_vec  = 0;
        n_miss = 0;
        rst = 1'b1;
        kp.key_valid = 1'b0; kp.key_code = 4'd0;
        kp.pass_ok = 1'b0; kp.pass_fail = 1'b0; kp.session_end = 1'b0;

        // Reset values
        #2 rst = 1'b0;
        #1;
        chk_all_zero("rst");
        chk("rst_locked", 32'(kp.locked),  32'h0);
        chk("rst_kerr",   32'(kp.key_err), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Normal session
        key(4'd1); key(4'd2); key(4'd3);
        chk("n_cnt3", 32'(kp.digit_count), 32'd3);
        key(c_ENT);
        chk("n_acct",  32'(kp.Account_Number), 32'h123);
        chk("n_ready", 32'(kp.acct_ready),     32'h1);
        chk("n_cnt0",  32'(kp.digit_count),    32'd0);
        chk("n_lc0",   32'(kp.LC),             32'h0);
        enter3(4'd1, 4'd2, 4'd3);
        chk("n_pin",   32'(kp.PIN), 32'h123);
        chk("n_lc1",   32'(kp.LC),  32'h1);
        strobe(1'b1, 1'b0, 1'b0);
        chk("n_done_lc",   32'(kp.LC),             32'h1);
        chk("n_done_acct", 32'(kp.Account_Number), 32'h123);
        strobe(1'b0, 1'b0, 1'b1);
        chk_all_zero("n_end");

        // Editing
        err_sum = 0;
        key(4'd4); err_sum += int'(kp.key_err);
        key(4'd5); err_sum += int'(kp.key_err);
        key(c_BCK); err_sum += int'(kp.key_err);
        chk("e_back_cnt", 32'(kp.digit_count), 32'd1);
        key(4'd6); err_sum += int'(kp.key_err);
        key(c_CLR); err_sum += int'(kp.key_err);
        chk("e_clr_cnt", 32'(kp.digit_count), 32'd0);
        key(4'd4); err_sum += int'(kp.key_err);
        key(4'd5); err_sum += int'(kp.key_err);
        key(4'd6); err_sum += int'(kp.key_err);
        key(4'd7);
        chk("e_err_on7", 32'(kp.key_err), 32'h1);
        err_sum += int'(kp.key_err);
        key(c_ENT); err_sum += int'(kp.key_err);
        chk("e_err_total", 32'(err_sum), 32'd1);
        chk("e_acct",  32'(kp.Account_Number), 32'h456);
        chk("e_ready", 32'(kp.acct_ready),     32'h1);
        key(4'd1); key(4'd2); key(c_ENT);
        chk("e_short_err", 32'(kp.key_err),     32'h1);
        chk("e_short_cnt", 32'(kp.digit_count), 32'd2);
        chk("e_short_lc",  32'(kp.LC),          32'h0);
        key(4'hF);
        chk("e_illegal_err", 32'(kp.key_err),     32'h1);
        chk("e_illegal_cnt", 32'(kp.digit_count), 32'd2);
        strobe(1'b0, 1'b0, 1'b1);
        chk_all_zero("e_end");

        // Retry and lockout
        enter3(4'd1, 4'd2, 4'd3);
        for (int t = 1; t <= c_MAX; t++) begin
            enter3(4'd9, 4'd8, 4'd7);
            chk("r_pin", 32'(kp.PIN), 32'h987);
            chk("r_lc1", 32'(kp.LC),  32'h1);
            strobe(1'b0, 1'b1, 1'b0);
            chk("r_lc0",    32'(kp.LC),          32'h0);
            chk("r_tries",  32'(kp.tries),       32'(t));
            chk("r_pinclr", 32'(kp.PIN),         32'h0);
            chk("r_cnt",    32'(kp.digit_count), 32'd0);
            chk("r_locked", 32'(kp.locked),      (t == c_MAX) ? 32'h1 : 32'h0);
        end
        lc = 0;
        while (kp.locked && lc < 200) begin
            kp.key_valid = (lc == 5);
            kp.key_code  = 4'd5;
            kp.pass_ok   = (lc == 8);
            lc++;
            @(negedge clk);
        end
        kp.key_valid = 1'b0;
        kp.pass_ok   = 1'b0;
        chk("l_len", 32'(lc), 32'(c_LOCK));
        chk_all_zero("l_exit");
        key(4'd3);
        chk("l_idle_cnt", 32'(kp.digit_count), 32'd1);
        strobe(1'b0, 1'b0, 1'b1);

        // Inactivity timeout, with a key dropped on the timeout cycle
        key(4'd7); key(4'd8);
        idle(c_TMO - 1);
        chk("t_pre_cnt", 32'(kp.digit_count), 32'd2);
        key(4'd4);
        chk("t_drop_cnt", 32'(kp.digit_count), 32'd0);
        chk("t_drop_err", 32'(kp.key_err),     32'h0);
        key(4'd9);
        chk("t_idle_cnt", 32'(kp.digit_count), 32'd1);
        strobe(1'b0, 1'b0, 1'b1);
        // A key on cycle 19 restarts the idle count
        key(4'd7); key(4'd8);
        idle(c_TMO - 2);
        key(4'd1);
        chk("t_rs_cnt3", 32'(kp.digit_count), 32'd3);
        idle(c_TMO - 1);
        chk("t_rs_hold", 32'(kp.digit_count), 32'd3);
        idle(1);
        chk("t_rs_out", 32'(kp.digit_count), 32'd0);
        key(4'd2);
        chk("t_rs_idle", 32'(kp.digit_count), 32'd1);
        strobe(1'b0, 1'b0, 1'b1);

        // Simultaneous events
        enter3(4'd1, 4'd2, 4'd3);
        enter3(4'd4, 4'd5, 4'd6);
        strobe(1'b0, 1'b1, 1'b0);
        chk("s_try1", 32'(kp.tries), 32'd1);
        enter3(4'd4, 4'd5, 4'd6);
        strobe(1'b1, 1'b1, 1'b0);
        chk("s_both_tries", 32'(kp.tries), 32'd1);
        chk("s_both_lc",    32'(kp.LC),    32'h1);
        strobe(1'b0, 1'b1, 1'b0);
        chk("s_done_fail", 32'(kp.tries), 32'd1);
        chk("s_done_pin",  32'(kp.PIN),   32'h456);
        strobe(1'b0, 1'b0, 1'b1);
        enter3(4'd1, 4'd2, 4'd3);
        key(4'd4); key(4'd5); key(4'd6);
        kp.session_end = 1'b1;
        key(c_ENT);
        kp.session_end = 1'b0;
        chk_all_zero("s_se_ent");
        key(4'd2);
        chk("s_se_idle", 32'(kp.digit_count), 32'd1);
        strobe(1'b0, 1'b0, 1'b1);

        // Asynchronous reset between edges
        enter3(4'd1, 4'd2, 4'd3);
        enter3(4'd7, 4'd7, 4'd7);
        chk("a_lc1", 32'(kp.LC), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("a_lc",   32'(kp.LC),             32'h0);
        chk("a_pin",  32'(kp.PIN),            32'h0);
        chk("a_acct", 32'(kp.Account_Number), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        key(4'd6);
        chk("a_next_cnt",   32'(kp.digit_count), 32'd1);
        chk("a_next_ready", 32'(kp.acct_ready),  32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/atm_keypad_entry.md
# atm_keypad_entry

Keypad front end for the ATM controller. It turns raw keypad strobes into the 12-bit BCD `Account_Number` and `PIN` words and the `LC` (PIN-loaded) level that the ATM core samples while it requests a PIN. It also enforces a per-card retry limit with a timed lockout and an inactivity timeout. It sits directly upstream of the ATM core and consumes the core's PIN verdict.

## Interface
Parameters:
- `MAX_TRIES`, default 3: failed PIN verdicts allowed before lockout (range 1–7).
- `TIMEOUT_CYCLES`, default 1000: idle cycles tolerated in ACCT/PIN before the session is abandoned.
- `LOCK_CYCLES`, default 5000: lockout duration.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-low.
- `key_valid`, in, 1: one-cycle strobe; `key_code` is valid this cycle.
- `key_code`, in, 4: key value. 0–9 are digits; 4'hA = CLEAR, 4'hB = BACK, 4'hE = ENTER; every other code is illegal.
- `pass_ok`, in, 1: one-cycle strobe from the core meaning the PIN was accepted.
- `pass_fail`, in, 1: one-cycle strobe from the core meaning the PIN was rejected.
- `session_end`, in, 1: one-cycle strobe meaning the customer exited.
- `Account_Number`, out, 12: three BCD digits; the first-entered digit is in [11:8].
- `PIN`, out, 12: three BCD digits, same packing.
- `acct_ready`, out, 1: `Account_Number` is stable and complete.
- `LC`, out, 1: `PIN` is stable and complete. Held high until a verdict arrives.
- `locked`, out, 1: the block is in LOCK.
- `key_err`, out, 1: one-cycle pulse for a rejected key.
- `digit_count`, out, 2: number of digits in the active buffer (0–3).
- `tries`, out, 3: failed verdicts so far in this session.

## Operation
States: IDLE, ACCT, PIN, WAIT, DONE, LOCK.

- **IDLE**
  - Any digit key: ACCT, with the digit loaded as the first digit.
  - Any other key: ignored, no error.
- **ACCT / PIN: buffer edits**
  - Digit with count < 3: buffer <= {buffer[7:0], digit}, count+1.
  - Digit with count == 3: ignored, `key_err` pulses.
  - CLEAR: buffer = 0, count = 0.
  - BACK with count > 0: buffer >> 4, count−1.
  - BACK with count == 0: `key_err` pulses.
  - Illegal code: `key_err` pulses, buffer unchanged.
- **ACCT / PIN: ENTER**
  - ENTER with count == 3 in ACCT: latch `Account_Number`, set `acct_ready`, go to PIN with an empty buffer.
  - ENTER with count == 3 in PIN: latch `PIN`, set `LC`, go to WAIT.
  - ENTER with count < 3: `key_err` pulses, state unchanged.
- **WAIT**
  - Keys are ignored with no error.
  - `pass_ok`: DONE.
  - `pass_fail`: `LC` clears and `tries` increments.
    - If the new `tries` == `MAX_TRIES`: LOCK.
    - Otherwise: PIN with the buffer and `PIN` cleared.
- **DONE**
  - Holds `Account_Number`, `PIN`, `acct_ready` and `LC`.
  - `session_end`: IDLE.
- **LOCK**
  - `locked` = 1. All keys and verdicts are ignored.
  - After `LOCK_CYCLES` cycles: IDLE.
- **Leaving for IDLE:** on entry to IDLE from any state, `Account_Number`, `PIN`, `acct_ready`, `LC`, `tries` and `digit_count` are zeroed.
- **Inactivity timer:** runs only in ACCT and PIN and restarts on any `key_valid`. When it reaches `TIMEOUT_CYCLES`, the next state is IDLE.
- **`session_end`:** accepted in any state except LOCK; the next state is IDLE.
- **Width rules:** timer and lock counters are sized with `$clog2` of their parameter and saturate; they never wrap. `tries` saturates at `MAX_TRIES`.

## Timing
- **Reset values:** state IDLE; every output 0; all counters 0.
- **Reset mid-operation:** asserting `rst` in any state forces the reset values immediately, without waiting for a clock edge.
- **Key latency:** a key accepted at edge N is reflected in the buffer, `digit_count` and state after edge N; `key_err` is high for the cycle following edge N.
- **ENTER latency:** `acct_ready` or `LC` rises in the cycle after the ENTER strobe.
- **Verdict latency:** `LC` falls in the cycle after `pass_fail`.
- **`LC` stability:** `LC` is a level, not a pulse. `PIN` does not change while `LC` = 1.
- **Simultaneous events, priority highest first:**
  1. `session_end`.
  2. `pass_ok`.
  3. `pass_fail`.
  4. Timeout.
  5. `key_valid`.
- **Both verdicts in one cycle:** `pass_ok` wins and `tries` is unchanged.
- **Verdicts outside WAIT:** ignored.
- **Timeout boundary:** a key arriving in the same cycle as the timeout is dropped.
- **Lock length:** LOCK lasts exactly `LOCK_CYCLES` cycles; `locked` is high for exactly that many cycles.

## Structure
Shared package `atm_pkg` holds:
- the key-code constants (`KEY_CLEAR`, `KEY_BACK`, `KEY_ENTER`);
- the state encoding type for this block;
- `DIGITS` = 3 and the BCD word width of 12, which the ATM core also imports.

One sub-module is natural: `bcd_digit_buffer`. It is a 3-deep nibble shift register with count, and supports push, pop, clear and full/empty flags. It is instantiated once and shared between ACCT and PIN. The FSM, timers and latch registers stay in the top module.

## Test plan
1. **Normal session:** keys 1, 2, 3, E, 1, 2, 3, E.
   - `Account_Number` = 12'h123 and `acct_ready` = 1 after the first E.
   - `PIN` = 12'h123 and `LC` = 1 after the second E.
   - `pass_ok` → DONE; `session_end` → all outputs 0.
2. **Editing:** keys 4, 5, B, 6, A, 4, 5, 6, 7, E.
   - `key_err` pulses once, on the 7.
   - `Account_Number` = 12'h456.
   - Then E with 2 digits gives `key_err`, with no state change.
3. **Retry and lockout** (`MAX_TRIES` = 3): three PIN entries each answered by `pass_fail`.
   - `tries` goes 1, 2, 3.
   - `LC` falls the cycle after each verdict.
   - `locked` = 1 for exactly `LOCK_CYCLES`, during which keys are ignored, then IDLE.
4. **Inactivity timeout** (`TIMEOUT_CYCLES` = 20): enter 7, 8, then idle for 20 cycles → IDLE with all outputs 0. A key at cycle 19 instead restarts the count.
5. **Simultaneous events:**
   - `pass_ok` and `pass_fail` in the same cycle → DONE with `tries` unchanged.
   - `session_end` together with ENTER in PIN → IDLE.
6. **Asynchronous reset:** pull `rst` low while in WAIT with `LC` = 1, between clock edges. `LC`, `PIN` and `Account_Number` drop to 0 without waiting for an edge, and the next key starts from IDLE.
